// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle add/sub/logic/shift, iterative
// shift-add multiply and restoring divide, one operation in flight.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               ov,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CW = SHW + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 ov_q, ov_d;

  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   shl;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH:0]       div_rem;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   step;

  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    shl     = {{WIDTH{1'b0}}, a} << b[SHW-1:0];

    // acc holds {partial product, remaining multiplier bits} for MUL and
    // {partial remainder, remaining dividend / quotient bits} for DIV.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    div_rem   = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
    if (op_q == OP_MUL) step = {mul_sum, acc_q[WIDTH-1:1]};
    else                step = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ov_d    = ov_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = opcode;
          state_d = S_DONE;
          ov_d    = 1'b0;
          case (opcode)
            OP_ADD: begin
              res_d = {{(WIDTH-1){1'b0}}, add_sum};
              ov_d  = add_sum[WIDTH];
            end
            OP_SUB: begin
              res_d = {{WIDTH{1'b0}}, a - b};
              ov_d  = (a < b);
            end
            OP_MUL: begin
              acc_d   = {{WIDTH{1'b0}}, b};
              cnt_d   = CW'(WIDTH);
              state_d = S_BUSY;
            end
            OP_DIV: begin
              if (b == '0) begin
                res_d = {a, {WIDTH{1'b1}}};
                ov_d  = 1'b1;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, a};
                cnt_d   = CW'(WIDTH);
                state_d = S_BUSY;
              end
            end
            OP_AND:  res_d = {{WIDTH{1'b0}}, a & b};
            OP_OR:   res_d = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  res_d = {{WIDTH{1'b0}}, a ^ b};
            default: res_d = shl;
          endcase
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        // Last bit is processed in the same cycle the counter hits zero.
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = step;
          ov_d    = (op_q == OP_MUL) && (step[2*WIDTH-1:WIDTH] != '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: every opcode, latency, handshake,
// backpressure and mid-operation reset, with hand-computed expected values.
module tb_alu_seq;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, in_valid, out_ready;
  logic           in_ready, out_valid, ov;
  logic [W-1:0]   a, b;
  logic [2:0]     opcode;
  logic [2*W-1:0] res;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_leak;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .opcode(opcode),
    .in_valid(in_valid), .in_ready(in_ready), .res(res), .ov(ov),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Present one request, then count edges until out_valid (bounded).
  task automatic issue(input logic [2:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       output int lat);
    @(negedge clk);
    opcode = op; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; opcode = 3'($urandom);
    lat = 0; ready_leak = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_leak++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== '0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b res=%h ov=%b expected 1 0 0 0",
               in_ready, out_valid, res, ov);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_cycle();
    logic [2:0]     ops[10];
    logic [W-1:0]   av[10], bv[10];
    logic [2*W-1:0] er[10];
    logic           eo[10];
    int lat;
    ops = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b111, 3'b111};
    av  = '{32'd1, 32'hFFFFFFFF, 32'd15, 32'd2, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'hFFFFFFFF};
    bv  = '{32'd2, 32'd1, 32'd5, 32'd15, 32'd2, 32'd2, 32'd2, 32'd2, 32'h23, 32'd31};
    er  = '{64'd3, 64'h1_00000000, 64'd10, 64'h0_FFFFFFF3, 64'd2, 64'd15, 64'd13, 64'd60, 64'd120,
            64'h7FFFFFFF_80000000};
    eo  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], av[i], bv[i], lat);
      n_checks++;
      if (lat !== 0 || res !== er[i] || ov !== eo[i]) begin
        n_fail++;
        $display("FAIL single_cycle[%0d]: lat=%0d res=%h ov=%b expected lat=0 res=%h ov=%b",
                 i, lat, res, ov, er[i], eo[i]);
      end
      take();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_cycle_take[%0d]: in_ready=%b out_valid=%b expected 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_iterative();
    logic [2:0]     ops[7];
    logic [W-1:0]   av[7], bv[7];
    logic [2*W-1:0] er[7];
    logic           eo[7];
    int             el[7];
    int lat;
    ops = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011};
    av  = '{32'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd15, 32'd15, 32'd100, 32'hFFFFFFFF};
    bv  = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd7, 32'd1};
    er  = '{64'd30, 64'h1_FFFFFFFE, 64'hFFFFFFFE_00000001, 64'h00000001_00000007,
            64'h0000000F_FFFFFFFF, 64'h00000002_0000000E, 64'h00000000_FFFFFFFF};
    eo  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    el  = '{W, W, W, W, 0, W, W};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], av[i], bv[i], lat);
      n_checks++;
      if (lat !== el[i] || ready_leak !== 0 || res !== er[i] || ov !== eo[i]) begin
        n_fail++;
        $display("FAIL iterative[%0d]: lat=%0d leak=%0d res=%h ov=%b expected lat=%0d leak=0 res=%h ov=%b",
                 i, lat, ready_leak, res, ov, el[i], er[i], eo[i]);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(3'b100, 32'd15, 32'd2, lat);
    @(negedge clk);
    in_valid = 1'b1; opcode = 3'b000; a = 32'd7; b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (res !== 64'd2 || ov !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: res=%h ov=%b out_valid=%b in_ready=%b expected 2 0 1 0",
                 i, res, ov, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    take();
    n_checks++;
    if (res !== 64'd2 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_take: res=%h in_ready=%b out_valid=%b expected 2 1 0",
               res, in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(3'b000, 32'd10, 32'd20, lat);
    // Request held during the take cycle must wait for the following edge.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; opcode = 3'b001; a = 32'd50; b = 32'd8;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 64'd30) begin
      n_fail++;
      $display("FAIL back_to_back_take: out_valid=%b in_ready=%b res=%h expected 0 1 1e",
               out_valid, in_ready, res);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || res !== 64'd42 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_second: out_valid=%b res=%h ov=%b expected 1 2a 0",
               out_valid, res, ov);
    end
    take();
  endtask

  task automatic test_rst_mid();
    int lat;
    @(negedge clk);
    opcode = 3'b010; a = 32'd15; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || res !== '0 || ov !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: out_valid=%b res=%h ov=%b in_ready=%b expected 0 0 0 1",
               out_valid, res, ov, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(3'b000, 32'd1, 32'd2, lat);
    n_checks++;
    if (lat !== 0 || res !== 64'd3 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_add: lat=%0d res=%h ov=%b expected 0 3 0", lat, res, ov);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_iterative();
    test_backpressure();
    test_back_to_back();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
